design05_sequencer: RTL
=======================

// Module: design05_sequencer
// PURPOSE
//   Two-requester round-robin sequencer sharing one mkDesign_05 instance.
//   - Per transaction, drives the DUT's start(a,b) action, then its
//     variable__check(d) actionvalue, and returns the 6-bit result to the winner.
//   - Sits between requester logic and the mkDesign_05 port set; owns all
//     EN_* strobes to that block.
// PARAMETERS
//   W            6    data width of a/b/d/result
//   CHK_TIMEOUT  16   max cycles waiting for RDY_variable__check before error abort
//   CW           5    timeout counter width, must satisfy 2**CW > CHK_TIMEOUT
// PORTS
//   CLK                  in   1   clock, rising edge
//   RST                  in   1   asynchronous, active-high reset
//   reqN_valid (N=0,1)   in   1   requester N presents a transaction
//   reqN_a/_b/_d         in   W   operands for start_a, start_b, check_d
//   reqN_ready           out  1   1-cycle grant pulse; operands latched this cycle
//   respN_valid          out  1   result for requester N pending
//   respN_data           out  W   captured variable__check value
//   respN_err            out  1   1 = check timed out, data forced 0
//   respN_ready          in   1   requester N consumes response
//   dut_start_a/_b       out  W   to start_a/start_b
//   dut_EN_start         out  1   to EN_start
//   dut_RDY_start        in   1   from RDY_start
//   dut_check_d          out  W   to variable__check_d
//   dut_EN_check         out  1   to EN_variable__check
//   dut_check_val        in   W   from variable__check
//   dut_RDY_check        in   1   from RDY_variable__check
//   busy                 out  1   state != IDLE
//   done_count           out  8   completed transactions (incl. errors), wraps 255->0
// BEHAVIOUR
//   Reset: state=IDLE, prio=0, all out regs 0, all EN/ready/valid outputs 0.
//   States: IDLE -> START -> CHECK -> RESP -> IDLE.
//   IDLE: if exactly one reqN_valid, grant it; if both, grant prio; reqN_ready=1
//     same cycle (combinational on valid & state); latch a,b,d, owner -> START.
//   START: dut_EN_start = dut_RDY_start (never EN without RDY); start_a/_b
//     driven from latches whole state. On fire -> CHECK, tmo counter=0.
//   CHECK: dut_EN_check = dut_RDY_check; dut_check_d from latch. On fire:
//     capture dut_check_val, err=0 -> RESP. Else counter++; when counter
//     reaches CHK_TIMEOUT with no fire: data=0, err=1 -> RESP, no EN issued.
//   RESP: resp<owner>_valid=1, data/err stable until resp<owner>_ready=1;
//     that cycle: -> IDLE, prio = ~owner, done_count++. Other resp stays 0.
//   Latency, RDY always 1: grant c0, EN_start c1, EN_check c2, resp_valid c3.
//   Only one transaction in flight; no request granted outside IDLE.
//   reqN_valid dropped before grant: ignored, no state change.
//   Timeout cycle with RDY_check rising same cycle: fire wins, err=0.
//   RST mid-transaction: immediate abort, no response ever issued, EN strobes
//     deassert asynchronously, prio back to 0.
// TESTING
//   1 Single req0 a=3,b=5,d=7, RDYs=1, dut_check_val=0x2A -> ready c0,
//     EN_start c1 (a=3,b=5), EN_check c2 (d=7), resp0_valid c3 data=0x2A err=0.
//   2 Both valid continuously, resp_ready=1 -> grants 0,1,0,1; done_count=4.
//   3 RDY_start low 5 cycles -> EN_start stays 0, fires cycle RDY rises;
//     resp unaffected otherwise.
//   4 RDY_check held 0, CHK_TIMEOUT=16 -> no EN_check, resp_err=1, data=0
//     after 16 CHECK cycles; next req proceeds normally.
//   5 resp1_ready held 0 for 10 cycles with req0 pending -> req0 not granted
//     until resp1 consumed; resp1_data stable throughout.
//   6 Assert RST during CHECK -> busy=0, EN_* =0 same cycle, no resp pulse;
//     done_count 0 after 300 wraps check: 256 txns -> done_count=0.

Source files
------------

// File: rtl/design05_sequencer_if.sv
// Handshake bundle between the round-robin sequencer, its two requesters
// and the mkDesign_05 port set it drives.
interface design05_sequencer_if #(
    parameter int W = 6
);
    logic         req0_valid;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic [W-1:0] req0_d;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic [W-1:0] req1_d;
    logic         req1_ready;

    logic         resp0_valid;
    logic [W-1:0] resp0_data;
    logic         resp0_err;
    logic         resp0_ready;
    logic         resp1_valid;
    logic [W-1:0] resp1_data;
    logic         resp1_err;
    logic         resp1_ready;

    logic [W-1:0] dut_start_a;
    logic [W-1:0] dut_start_b;
    logic         dut_EN_start;
    logic         dut_RDY_start;
    logic [W-1:0] dut_check_d;
    logic         dut_EN_check;
    logic [W-1:0] dut_check_val;
    logic         dut_RDY_check;

    logic         busy;
    logic [7:0]   done_count;

    // Sequencer side
    modport master (
        input  req0_valid, req0_a, req0_b, req0_d,
        input  req1_valid, req1_a, req1_b, req1_d,
        output req0_ready, req1_ready,
        output resp0_valid, resp0_data, resp0_err,
        output resp1_valid, resp1_data, resp1_err,
        input  resp0_ready, resp1_ready,
        output dut_start_a, dut_start_b, dut_EN_start,
        input  dut_RDY_start,
        output dut_check_d, dut_EN_check,
        input  dut_check_val, dut_RDY_check,
        output busy, done_count
    );

    // Requester / mkDesign_05 side
    modport slave (
        output req0_valid, req0_a, req0_b, req0_d,
        output req1_valid, req1_a, req1_b, req1_d,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp0_data, resp0_err,
        input  resp1_valid, resp1_data, resp1_err,
        output resp0_ready, resp1_ready,
        input  dut_start_a, dut_start_b, dut_EN_start,
        output dut_RDY_start,
        input  dut_check_d, dut_EN_check,
        output dut_check_val, dut_RDY_check,
        input  busy, done_count
    );
endinterface

// File: rtl/design05_sequencer.sv
// Two-requester round-robin sequencer in front of one mkDesign_05 instance.
// Each transaction fires start(a,b), then variable__check(d), and hands the
// captured result (or a timeout error) back to the requester that won.
module design05_sequencer #(
    parameter int W           = 6,
    parameter int CHK_TIMEOUT = 16,
    parameter int CW          = 5
) (
    input  logic                 CLK,
    input  logic                 RST,
    design05_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_CHECK,
        S_RESP
    } state_t;

    localparam logic [CW-1:0] TMO_LAST = CW'(CHK_TIMEOUT - 1);

    state_t       state_q, state_d;
    logic         prio_q, prio_d;
    logic         owner_q, owner_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] d_q, d_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [W-1:0] data_q, data_d;
    logic         err_q, err_d;
    logic [7:0]   done_q, done_d;

    logic grant0, grant1;
    logic start_fire, check_fire, resp_take;

    // Arbitration and handshake strobes; EN only ever follows its RDY
    always_comb begin
        grant0     = !RST && (state_q == S_IDLE) && bus.req0_valid
                     && (!bus.req1_valid || !prio_q);
        grant1     = !RST && (state_q == S_IDLE) && bus.req1_valid
                     && (!bus.req0_valid || prio_q);
        start_fire = (state_q == S_START) && bus.dut_RDY_start;
        check_fire = (state_q == S_CHECK) && bus.dut_RDY_check;
        resp_take  = (state_q == S_RESP)
                     && (owner_q ? bus.resp1_ready : bus.resp0_ready);
    end

    // Next-state and datapath: one transaction walks IDLE->START->CHECK->RESP
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        tmo_d   = tmo_q;
        data_d  = data_q;
        err_d   = err_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE: begin
                if (grant0 || grant1) begin
                    owner_d = grant1;
                    a_d     = grant1 ? bus.req1_a : bus.req0_a;
                    b_d     = grant1 ? bus.req1_b : bus.req0_b;
                    d_d     = grant1 ? bus.req1_d : bus.req0_d;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (start_fire) begin
                    tmo_d   = '0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (check_fire) begin
                    data_d  = bus.dut_check_val;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_RESP: begin
                if (resp_take) begin
                    prio_d  = ~owner_q;
                    done_d  = done_q + 8'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any transaction in flight immediately
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            tmo_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign bus.req0_ready   = grant0;
    assign bus.req1_ready   = grant1;
    assign bus.dut_start_a  = a_q;
    assign bus.dut_start_b  = b_q;
    assign bus.dut_EN_start = start_fire;
    assign bus.dut_check_d  = d_q;
    assign bus.dut_EN_check = check_fire;
    assign bus.resp0_valid  = (state_q == S_RESP) && !owner_q;
    assign bus.resp1_valid  = (state_q == S_RESP) && owner_q;
    assign bus.resp0_data   = bus.resp0_valid ? data_q : '0;
    assign bus.resp1_data   = bus.resp1_valid ? data_q : '0;
    assign bus.resp0_err    = bus.resp0_valid && err_q;
    assign bus.resp1_err    = bus.resp1_valid && err_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done_count   = done_q;

endmodule
